// File: rtl/zbuf_pkg.sv
// Shared types for the Z-buffered pixel writer: FSM states, queued pixel entry, far-plane depth.
package zbuf_pkg;

   localparam int Z_W     = 16;
   localparam int COLOR_W = 16;
   localparam int ADDR_W  = 19;

   localparam logic [Z_W-1:0] Z_FAR = '1;

   typedef enum logic [1:0] {
      IDLE,
      COMPARE,
      CLEAR
   } state_t;

   typedef struct packed {
      logic [ADDR_W-1:0]  addr;
      logic [Z_W-1:0]     z;
      logic [COLOR_W-1:0] color;
   } pixel_entry_t;

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO of pixel entries; push and pop in the same cycle are legal, even when full.
module pixel_fifo
   import zbuf_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  pixel_entry_t push_data,
   input  logic         pop,
   output pixel_entry_t head,
   output logic         full,
   output logic         empty
);

   localparam int PW = $clog2(DEPTH);

   pixel_entry_t  mem_q [DEPTH];
   pixel_entry_t  mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; validity is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign head  = mem_q[rd_ptr_q];
   assign full  = (count_q == (PW+1)'(DEPTH));
   assign empty = (count_q == '0);

endmodule

// File: rtl/zbuf_pixel_writer.sv
// Queues plotted pixels, performs a read-compare-write depth test against the Z-buffer, writes
// colour on pass, and sequences a full depth-buffer clear to Z_FAR on request.
module zbuf_pixel_writer
   import zbuf_pkg::*;
#(
   parameter int SCREEN_W   = 640,
   parameter int SCREEN_H   = 480,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               plot,
   input  logic [10:0]        x,
   input  logic [10:0]        y,
   input  logic [Z_W-1:0]     z_in,
   input  logic [COLOR_W-1:0] color,
   input  logic               clear_start,
   output logic [ADDR_W-1:0]  zb_addr,
   output logic               zb_rd,
   input  logic [Z_W-1:0]     zb_rdata,
   output logic               zb_we,
   output logic [Z_W-1:0]     zb_wdata,
   output logic [ADDR_W-1:0]  fb_addr,
   output logic               fb_we,
   output logic [COLOR_W-1:0] fb_wdata,
   output logic               busy,
   output logic               overflow,
   output logic               clear_done
);

   localparam int                NUM_PIXELS  = SCREEN_W * SCREEN_H;
   localparam logic [10:0]       X_LIMIT     = 11'(SCREEN_W);
   localparam logic [10:0]       Y_LIMIT     = 11'(SCREEN_H);
   localparam logic [ADDR_W-1:0] LINE_STRIDE = ADDR_W'(SCREEN_W);
   localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(NUM_PIXELS - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
   logic              pend_q, pend_d;
   logic              ovf_q, ovf_d;
   logic              done_q, done_d;
   pixel_entry_t      lat_q, lat_d;

   logic         in_bounds;
   logic         push;
   logic         pop;
   logic         drop;
   logic         fifo_full;
   logic         fifo_empty;
   pixel_entry_t new_entry;
   pixel_entry_t head;

   // The address is formed at enqueue time so the queue holds addresses, not coordinates.
   assign in_bounds = (x < X_LIMIT) && (y < Y_LIMIT);
   assign new_entry = '{addr:  ADDR_W'(y) * LINE_STRIDE + ADDR_W'(x),
                        z:     z_in,
                        color: color};
   assign push      = plot && in_bounds && (!fifo_full || pop);
   assign drop      = plot && in_bounds && fifo_full && !pop;

   pixel_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .push_data(new_entry),
      .pop      (pop),
      .head     (head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      pend_d    = pend_q;
      ovf_d     = ovf_q;
      done_d    = 1'b0;
      lat_d     = lat_q;
      pop       = 1'b0;
      zb_addr   = '0;
      zb_rd     = 1'b0;
      zb_we     = 1'b0;
      zb_wdata  = '0;
      fb_addr   = '0;
      fb_we     = 1'b0;
      fb_wdata  = '0;

      if (clear_start && (state_q != CLEAR)) begin
         pend_d = 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (pend_q) begin
               state_d   = CLEAR;
               clr_cnt_d = '0;
               pend_d    = 1'b0;
               ovf_d     = 1'b0;
            end else if (!fifo_empty) begin
               pop     = 1'b1;
               zb_rd   = 1'b1;
               zb_addr = head.addr;
               lat_d   = head;
               state_d = COMPARE;
            end
         end
         COMPARE: begin
            // Strictly closer wins; equal depth keeps the existing pixel.
            if (lat_q.z < zb_rdata) begin
               zb_we    = 1'b1;
               fb_we    = 1'b1;
               zb_addr  = lat_q.addr;
               fb_addr  = lat_q.addr;
               zb_wdata = lat_q.z;
               fb_wdata = lat_q.color;
            end
            state_d = IDLE;
         end
         CLEAR: begin
            zb_we    = 1'b1;
            zb_wdata = Z_FAR;
            zb_addr  = clr_cnt_q;
            if (clr_cnt_q == LAST_ADDR) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               clr_cnt_d = clr_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (drop) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         clr_cnt_q <= '0;
         pend_q    <= 1'b0;
         ovf_q     <= 1'b0;
         done_q    <= 1'b0;
         lat_q     <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         pend_q    <= pend_d;
         ovf_q     <= ovf_d;
         done_q    <= done_d;
         lat_q     <= lat_d;
      end
   end

   assign busy       = (state_q != IDLE) || !fifo_empty || pend_q;
   assign overflow   = ovf_q;
   assign clear_done = done_q;

endmodule
